// File: rtl/illm_row_serializer_if.sv
// Handshake bundle between the 8-lane IDCT row stage and the serial output stage.
// The master side drives the eight input lanes and accepts the serial stream;
// the slave side is the row serializer itself.
interface illm_row_serializer_if #(
    parameter int W = 16
);
    logic [W-1:0] i0_d, i1_d, i2_d, i3_d, i4_d, i5_d, i6_d, i7_d;
    logic         i0_e, i1_e, i2_e, i3_e, i4_e, i5_e, i6_e, i7_e;
    logic         i0_v, i1_v, i2_v, i3_v, i4_v, i5_v, i6_v, i7_v;
    logic         i0_b, i1_b, i2_b, i3_b, i4_b, i5_b, i6_b, i7_b;
    logic [W-1:0] o_d;
    logic         o_e;
    logic         o_v;
    logic         o_b;

    modport master (
        output i0_d, i1_d, i2_d, i3_d, i4_d, i5_d, i6_d, i7_d,
        output i0_e, i1_e, i2_e, i3_e, i4_e, i5_e, i6_e, i7_e,
        output i0_v, i1_v, i2_v, i3_v, i4_v, i5_v, i6_v, i7_v,
        input  i0_b, i1_b, i2_b, i3_b, i4_b, i5_b, i6_b, i7_b,
        input  o_d, o_e, o_v,
        output o_b
    );

    modport slave (
        input  i0_d, i1_d, i2_d, i3_d, i4_d, i5_d, i6_d, i7_d,
        input  i0_e, i1_e, i2_e, i3_e, i4_e, i5_e, i6_e, i7_e,
        input  i0_v, i1_v, i2_v, i3_v, i4_v, i5_v, i6_v, i7_v,
        output i0_b, i1_b, i2_b, i3_b, i4_b, i5_b, i6_b, i7_b,
        output o_d, o_e, o_v,
        input  o_b
    );
endinterface

// File: rtl/illm_row_serializer.sv
// Row serializer: captures one complete 8-element IDCT row atomically from the
// eight input lanes and replays it element by element on a single stream.
// An all-lane end-of-stream token becomes one serial EOS token; a row whose
// lanes disagree about EOS is a protocol error that locks the input until reset.
module illm_row_serializer #(
    parameter int W     = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    illm_row_serializer_if.slave bus,
    output logic [CNT_W-1:0]     rows,
    output logic                 err
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        EOSO
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [2:0]   idx_q;
    logic [W-1:0] row_buf [8];

    logic [W-1:0] lane_d [8];
    logic [7:0]   lane_v;
    logic [7:0]   lane_e;

    logic all_v;
    logic all_d;
    logic all_e;
    logic mixed;
    logic can_take;
    logic acc;

    logic load_row;
    logic idx_inc;
    logic row_done;
    logic set_err;

    assign lane_d[0] = bus.i0_d;
    assign lane_d[1] = bus.i1_d;
    assign lane_d[2] = bus.i2_d;
    assign lane_d[3] = bus.i3_d;
    assign lane_d[4] = bus.i4_d;
    assign lane_d[5] = bus.i5_d;
    assign lane_d[6] = bus.i6_d;
    assign lane_d[7] = bus.i7_d;

    assign lane_v = {bus.i7_v, bus.i6_v, bus.i5_v, bus.i4_v,
                     bus.i3_v, bus.i2_v, bus.i1_v, bus.i0_v};
    assign lane_e = {bus.i7_e, bus.i6_e, bus.i5_e, bus.i4_e,
                     bus.i3_e, bus.i2_e, bus.i1_e, bus.i0_e};

    // A row is only ever taken as a whole: all lanes valid and all agreeing on EOS.
    // Acceptance is possible from IDLE, or on the very cycle the last element of
    // the current row leaves, so consecutive rows stream without a bubble.
    // Holding reset low forces backpressure even though the FSM already sits in IDLE.
    assign all_v    = &lane_v;
    assign all_d    = all_v && (lane_e == 8'h00);
    assign all_e    = all_v && (lane_e == 8'hFF);
    assign mixed    = all_v && !all_d && !all_e;
    assign can_take = (state_q == IDLE) ||
                      ((state_q == SEND) && (idx_q == 3'd7) && !bus.o_b);
    assign acc      = reset && can_take && (all_d || all_e) && !err;

    assign bus.i0_b = !acc;
    assign bus.i1_b = !acc;
    assign bus.i2_b = !acc;
    assign bus.i3_b = !acc;
    assign bus.i4_b = !acc;
    assign bus.i5_b = !acc;
    assign bus.i6_b = !acc;
    assign bus.i7_b = !acc;

    assign bus.o_v = (state_q != IDLE);
    assign bus.o_e = (state_q == EOSO);
    assign bus.o_d = (state_q == SEND) ? row_buf[idx_q] : '0;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the strobes that steer the row buffer, index, counter and error flag.
    always_comb begin
        state_d  = state_q;
        load_row = 1'b0;
        idx_inc  = 1'b0;
        row_done = 1'b0;
        set_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc && all_d) begin
                    state_d  = SEND;
                    load_row = 1'b1;
                end else if (acc && all_e) begin
                    state_d = EOSO;
                end else if (mixed) begin
                    set_err = 1'b1;
                end
            end
            SEND: begin
                if (!bus.o_b) begin
                    if (idx_q != 3'd7) begin
                        idx_inc = 1'b1;
                    end else begin
                        row_done = 1'b1;
                        if (acc && all_d) begin
                            load_row = 1'b1;
                        end else if (acc && all_e) begin
                            state_d = EOSO;
                        end else begin
                            state_d = IDLE;
                            if (mixed) begin
                                set_err = 1'b1;
                            end
                        end
                    end
                end
            end
            EOSO: begin
                if (!bus.o_b) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Row buffer, element index, completed-row counter and the sticky error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_q <= 3'd0;
            rows  <= '0;
            err   <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                row_buf[k] <= '0;
            end
        end else begin
            if (load_row) begin
                for (int k = 0; k < 8; k++) begin
                    row_buf[k] <= lane_d[k];
                end
            end
            if (load_row || row_done) begin
                idx_q <= 3'd0;
            end else if (idx_inc) begin
                idx_q <= idx_q + 3'd1;
            end
            if (row_done) begin
                rows <= rows + 1'b1;
            end
            if (set_err) begin
                err <= 1'b1;
            end
        end
    end

endmodule
